// File: rtl/pipeline_mem_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory bus between the
// instruction-fetch and data-access requesters of the pipeline.
module pipeline_mem_arbiter #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [XLEN-1:0]       i_rdata,
  output logic                  i_done,
  input  logic                  d_req,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [XLEN-1:0]       d_wdata,
  input  logic [XLEN/8-1:0]     d_wmask,
  output logic [XLEN-1:0]       d_rdata,
  output logic                  d_done,
  output logic                  mem_valid,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  output logic [XLEN/8-1:0]     mem_wmask,
  input  logic                  mem_ready,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic                  want_stall
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  state_t state_r;
  logic   last_grant_r;
  logic   i_pend_s;
  logic   d_pend_s;
  logic   grant_i_s;
  logic   grant_d_s;

  // A requester whose done pulse is showing is finished and must not be re-granted.
  always_comb begin
    i_pend_s  = i_req & ~i_done;
    d_pend_s  = d_req & ~d_done;
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (i_pend_s && d_pend_s) begin
      grant_d_s = (last_grant_r == GRANT_FETCH);
      grant_i_s = (last_grant_r == GRANT_DATA);
    end else begin
      grant_d_s = d_pend_s;
      grant_i_s = i_pend_s;
    end
  end

  assign want_stall = (i_req & ~i_done) | (d_req & ~d_done);

  // Bus sequencing FSM with all bus fields, captured data and done pulses registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      last_grant_r <= GRANT_FETCH;
      mem_valid    <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wmask    <= '0;
      i_done       <= 1'b0;
      d_done       <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_d_s) begin
            state_r   <= DATA;
            mem_valid <= 1'b1;
            mem_write <= d_write;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wmask <= d_write ? d_wmask : '0;
          end else if (grant_i_s) begin
            state_r   <= FETCH;
            mem_valid <= 1'b1;
            mem_write <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            mem_wmask <= '0;
          end else begin
            state_r   <= IDLE;
            mem_valid <= 1'b0;
          end
        end
        FETCH: begin
          if (mem_ready) begin
            state_r      <= IDLE;
            mem_valid    <= 1'b0;
            i_rdata      <= mem_rdata;
            i_done       <= 1'b1;
            last_grant_r <= GRANT_FETCH;
          end else begin
            state_r <= FETCH;
          end
        end
        DATA: begin
          if (mem_ready) begin
            state_r      <= IDLE;
            mem_valid    <= 1'b0;
            d_done       <= 1'b1;
            last_grant_r <= GRANT_DATA;
            if (!mem_write) begin
              d_rdata <= mem_rdata;
            end else begin
              d_rdata <= d_rdata;
            end
          end else begin
            state_r <= DATA;
          end
        end
        default: begin
          state_r   <= IDLE;
          mem_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
